// File: rtl/rca_pipe_if.sv
// Handshake and data bundle between an rca_pipe and its producer/consumer.
// The ovf wire exists only when RCA_PIPE_OVF_EN is defined.
interface rca_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, op, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );
  modport slave (
    input  in_valid, a, b, ci, op, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
`else
  modport master (
    output in_valid, a, b, ci, op, out_ready,
    input  in_ready, out_valid, s, co
  );
  modport slave (
    input  in_valid, a, b, ci, op, out_ready,
    output in_ready, out_valid, s, co
  );
`endif
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry add/subtract: input register, then STAGES carry segments, one op per clock.
// Latency STAGES cycles accept-to-out_valid; global stall holds every stage while the output waits.
// RCA_PIPE_OVF_EN adds a registered signed-overflow flag (ovf) alongside s/co.
module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       reset_n,
  rca_pipe_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  // a_q carries the operand A on entry; each stage overwrites its segment with sum bits,
  // so the last a_q is the finished sum. b_q is never needed past the last segment.
  logic [WIDTH-1:0] a_q     [STAGES+1];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             c_q     [STAGES+1];
  logic             v_q     [STAGES+1];
  logic [WIDTH-1:0] a_nxt   [STAGES];
  logic [SEG:0]     seg_sum [STAGES];
  logic             advance;

  assign advance       = ~v_q[STAGES] | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[STAGES];
  assign bus.s         = a_q[STAGES];
  assign bus.co        = c_q[STAGES];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_q[k][k*SEG +: SEG]} + {1'b0, b_q[k][k*SEG +: SEG]}
                 + (SEG+1)'(c_q[k]);
      a_nxt[k]   = a_q[k];
      a_nxt[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        b_q[k] <= '0;
      end
    end else if (advance) begin
      v_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        a_q[0] <= bus.a;
        b_q[0] <= bus.b ^ {WIDTH{bus.op}};
        c_q[0] <= bus.ci;
      end
      for (int k = 0; k < STAGES; k++) begin
        v_q[k+1] <= v_q[k];
        a_q[k+1] <= a_nxt[k];
        c_q[k+1] <= seg_sum[k][SEG];
      end
      for (int k = 1; k < STAGES; k++) begin
        b_q[k] <= b_q[k-1];
      end
    end
  end

`ifdef RCA_PIPE_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  logic ovf_q;
  logic ovf_nxt;

  assign ovf_nxt = seg_sum[STAGES-1][SEG]
                 ^ (a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1] ^ seg_sum[STAGES-1][SEG-1]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe (WIDTH=32, STAGES=4): directed vectors plus random traffic vs a queue model.
module tb_rca_pipe;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  logic [33:0] exp_q[$];

  rca_pipe_if #(.WIDTH(32)) bus ();

  rca_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, co, s} from plain wide arithmetic.
  function automatic logic [33:0] ref_res(input logic [31:0] xa, input logic [31:0] xb,
                                          input logic xci, input logic xop);
    logic [31:0] bo;
    logic [32:0] sum;
    logic        v;
    bo  = xop ? ~xb : xb;
    sum = {1'b0, xa} + {1'b0, bo} + 33'(xci);
    v   = (xa[31] == bo[31]) && (sum[31] != xa[31]);
    return {v, sum};
  endfunction

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        input logic xci, input logic xop, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = xa;
    bus.b         = xb;
    bus.ci        = xci;
    bus.op        = xop;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.s !== 32'h0) begin fails++; $display("FAIL reset_s got=%h exp=0", bus.s); end
    tests++; if (bus.co !== 1'b0) begin fails++; $display("FAIL reset_co got=%b exp=0", bus.co); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_carry();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL carry_latency got=%0d exp=4", lat); end
    tests++; if (bus.s !== 32'h0) begin fails++; $display("FAIL carry_s got=%h exp=00000000", bus.s); end
    tests++; if (bus.co !== 1'b1) begin fails++; $display("FAIL carry_co got=%b exp=1", bus.co); end
  endtask

  task automatic test_subtract();
    int lat;
    run_op(32'd5, 32'd7, 1'b1, 1'b1, lat);
    tests++; if (bus.s !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sub57_s got=%h exp=fffffffe", bus.s); end
    tests++; if (bus.co !== 1'b0) begin fails++; $display("FAIL sub57_co got=%b exp=0", bus.co); end
    run_op(32'd7, 32'd5, 1'b1, 1'b1, lat);
    tests++; if (bus.s !== 32'h2) begin fails++; $display("FAIL sub75_s got=%h exp=00000002", bus.s); end
    tests++; if (bus.co !== 1'b1) begin fails++; $display("FAIL sub75_co got=%b exp=1", bus.co); end
  endtask

`ifdef RCA_PIPE_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    tests++; if (bus.s !== 32'h8000_0000) begin fails++; $display("FAIL ovf_s got=%h exp=80000000", bus.s); end
    tests++; if (bus.co !== 1'b0) begin fails++; $display("FAIL ovf_co got=%b exp=0", bus.co); end
    tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", bus.ovf); end
    run_op(32'h1, 32'h1, 1'b0, 1'b0, lat);
    tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", bus.ovf); end
  endtask
`endif

  task automatic test_stall();
    int          idx;
    int          nexp;
    int          stall;
    int          got;
    int          extra;
    logic [31:0] e32;
    idx   = 1;
    nexp  = 1;
    stall = -1;
    got   = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      bus.in_valid = (idx <= 8);
      bus.a        = 32'(idx);
      bus.b        = 32'(idx);
      bus.ci       = 1'b0;
      bus.op       = 1'b0;
      if (stall < 0 && bus.out_valid) stall = 3;
      bus.out_ready = !(stall > 0);
      #1;
      if (stall > 0) begin
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
        stall--;
      end
      if (bus.out_valid && bus.out_ready) begin
        e32 = 32'(2 * nexp);
        tests++; if (bus.s !== e32 || bus.co !== 1'b0) begin
          fails++; $display("FAIL stall_result got=%h/%b exp=%h/0", bus.s, bus.co, e32);
        end
        nexp++;
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    tests++; if (got !== 8) begin fails++; $display("FAIL stall_count got=%0d exp=8", got); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL stall_duplicates got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_in_flight();
    int stale;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.ci        = 1'b0;
      bus.op        = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flight_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.s !== 32'h0) begin fails++; $display("FAIL flight_s got=%h exp=0", bus.s); end
    reset_n = 1'b1;
    stale   = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    tests++; if (stale !== 0) begin fails++; $display("FAIL flight_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_random();
    logic [33:0] e;
    logic [32:0] prev;
    logic        held;
    held = 1'b0;
    prev = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0) && (cyc < 360);
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.ci        = 1'($urandom_range(0, 1));
      bus.op        = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0) || (cyc >= 360);
      #1;
      if (held) begin
        tests++; if ({bus.co, bus.s} !== prev) begin
          fails++; $display("FAIL rand_hold got=%h exp=%h", {bus.co, bus.s}, prev);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_unexpected got=%h exp=none", {bus.co, bus.s});
        end else begin
          e = exp_q.pop_front();
`ifdef RCA_PIPE_OVF_EN
          if ({bus.ovf, bus.co, bus.s} !== e) begin
            fails++; $display("FAIL rand_result got=%h exp=%h", {bus.ovf, bus.co, bus.s}, e);
          end
`else
          if ({bus.co, bus.s} !== e[32:0]) begin
            fails++; $display("FAIL rand_result got=%h exp=%h", {bus.co, bus.s}, e[32:0]);
          end
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_res(bus.a, bus.b, bus.ci, bus.op));
      held = bus.out_valid && !bus.out_ready;
      prev = {bus.co, bus.s};
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_drain got=%0d exp=0 pending", exp_q.size()); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_carry();
    test_subtract();
`ifdef RCA_PIPE_OVF_EN
    test_ovf();
`endif
    test_stall();
    test_reset_in_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
